// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle, with single-cycle answers for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [AW-1:0]   rd_out,
    output logic            we
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;

    // Operand decode for the instruction being offered this cycle.
    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast, accept;
    logic [XLEN-1:0] fast_val;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sa       = a_signed && rs1_data[XLEN-1];
        sb       = b_signed && rs2_data[XLEN-1];
        a_mag    = sa ? -rs1_data : rs1_data;
        b_mag    = sb ? -rs2_data : rs2_data;
        div_zero = funct3[2] && (rs2_data == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1_data == MOST_NEG) && (rs2_data == '1);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_val = funct3[1] ? rs1_data : '1;
        else
            fast_val = funct3[1] ? '0 : rs1_data;
        accept   = start && !flush && ((state == IDLE) || (state == DONE));
    end

    // Multiply and divide share the double-width accumulator: {hi, lo}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   mul_tmp;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_fits;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, final_val;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_tmp   = {mul_sum, acc[XLEN-1:0]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_fits  = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[XLEN-1:0] - opnd;
        if (op[2])
            step = div_fits ? {div_diff, acc[XLEN-2:0], 1'b1}
                            : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            step = mul_tmp[2*XLEN:1];

        prod = neg ? -step : step;
        quo  = neg ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = neg ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (op[2])
            final_val = op[1] ? rem : quo;
        else
            final_val = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            op     <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            if (accept) begin
                op     <= funct3;
                rd_out <= rd_in;
                neg    <= funct3[2] ? (funct3[1] ? sa : (sa ^ sb)) : (sa ^ sb);
                count  <= '0;
                if (fast) begin
                    result <= fast_val;
                    state  <= DONE;
                end else begin
                    // Divide shifts the dividend out of lo; multiply shifts the multiplier.
                    opnd  <= funct3[2] ? b_mag : a_mag;
                    acc   <= {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
                    state <= CALC;
                end
            end else begin
                case (state)
                    CALC: begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            acc   <= step;
                            count <= count + CW'(1);
                            if (count == CW'(XLEN - 1)) begin
                                result <= final_val;
                                state  <= DONE;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);
    assign we   = done && (rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for each operation plus sequences for
// ignored start, flush, back-to-back issue and asynchronous reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we;

    muldiv_unit #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we(we)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
    endtask

    task automatic accept_edge();
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        drive(f3, a, b, rd);
        accept_edge();
    endtask

    // Called just after the accept edge; lat=1 means done in the cycle right after it.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
        logic        we;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat, bcyc, ndone;

        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b1});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33, 1'b1});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 33, 1'b1});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33, 1'b1});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 33, 1'b1});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, 33, 1'b1});
        vecs.push_back('{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd6,  32'h2345_6780, 33, 1'b1});
        vecs.push_back('{3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        33, 1'b1});
        vecs.push_back('{3'b111, 32'd100,       32'd7,         5'd8,  32'd2,         33, 1'b1});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33, 1'b1});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33, 1'b1});
        vecs.push_back('{3'b100, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33, 1'b1});
        vecs.push_back('{3'b110, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         33, 1'b1});
        vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         33, 1'b1});
        vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 33, 1'b1});
        vecs.push_back('{3'b100, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1,  1'b1});
        vecs.push_back('{3'b110, 32'd5,         32'd0,         5'd16, 32'd5,         1,  1'b1});
        vecs.push_back('{3'b101, 32'd7,         32'd0,         5'd17, 32'hFFFF_FFFF, 1,  1'b1});
        vecs.push_back('{3'b111, 32'd7,         32'd0,         5'd18, 32'd7,         1,  1'b1});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1,  1'b1});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1,  1'b1});
        vecs.push_back('{3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        33, 1'b0});

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_we",     32'(we),     32'd0);
        check("reset_result", result,      32'd0);
        check("reset_rd_out", 32'(rd_out), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_done(lat, bcyc);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bcyc), (vecs[i].lat == 1) ? 32'd0 : 32'd32);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_rd_out", i), 32'(rd_out), 32'(vecs[i].rd));
            check($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // Second start while busy must not disturb the in-flight multiply.
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) drive(3'b101, 32'd100, 32'd7, 5'd9);
            if (k == 6) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("ignore_latency", 32'(lat), 32'd33);
        check("ignore_result", result, 32'hFFFF_FFEB);
        check("ignore_rd_out", 32'(rd_out), 32'd3);
        @(negedge clk);
        check("ignore_idle_busy", 32'(busy), 32'd0);

        // Flush mid-calculation, with a start in the same cycle that must be dropped.
        issue(3'b000, 32'd3, 32'd4, 5'd6);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        flush = 1'b1;
        drive(3'b000, 32'd5, 32'd6, 5'd7);
        @(posedge clk);
        #1 begin flush = 1'b0; start = 1'b0; end
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_no_done", 32'(ndone), 32'd0);

        // Back-to-back: start during the done cycle of an rd=0 multiply.
        issue(3'b000, 32'd3, 32'd4, 5'd0);
        wait_done(lat, bcyc);
        check("b2b_first_latency", 32'(lat), 32'd33);
        check("b2b_first_result", result, 32'd12);
        check("b2b_first_we", 32'(we), 32'd0);
        drive(3'b101, 32'd100, 32'd7, 5'd4);
        accept_edge();
        wait_done(lat, bcyc);
        check("b2b_second_latency", 32'(lat), 32'd33);
        check("b2b_second_busy", 32'(bcyc), 32'd32);
        check("b2b_second_result", result, 32'd14);
        check("b2b_second_we", 32'(we), 32'd1);

        // Asynchronous reset in the middle of an operation clears outputs immediately.
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        repeat (20) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_we",     32'(we),     32'd0);
        check("rst_result", result,      32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
